// File: rtl/bus_arb_pkg.sv
// Shared bus arbiter definitions: phase encoding (common with the master
// interface FSM) and default sizing constants.
package bus_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GRANT  = 3'd1,
      ST_ADDR   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DATA   = 3'd4,
      ST_FINISH = 3'd5
   } bus_phase_e;

   localparam int NUM_MASTERS_DEF = 4;
   localparam int TIMEOUT_DEF     = 255;
   localparam int TMO_W_DEF       = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: scans req starting at ptr, wrapping
// modulo NUM_MASTERS, and returns the first requester found.
module rr_picker
   import bus_arb_pkg::*;
#(
   parameter int NUM_MASTERS = NUM_MASTERS_DEF,
   parameter int ID_W        = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [ID_W-1:0]        ptr,
   output logic                   valid,
   output logic [ID_W-1:0]        winner
);

   logic [ID_W:0] idx_s;

   // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx_s  = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         idx_s = {1'b0, ptr} + (ID_W + 1)'(i);
         idx_s = (idx_s >= (ID_W + 1)'(NUM_MASTERS)) ? (idx_s - (ID_W + 1)'(NUM_MASTERS)) : idx_s;
         if (req[idx_s[ID_W-1:0]]) begin
            valid  = 1'b1;
            winner = idx_s[ID_W-1:0];
         end else begin
            valid  = valid;
            winner = winner;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system bus arbiter: one-cycle grant, ADDR/WAIT/DATA/FINISH
// phase tracking in lockstep with the master FSM, and WAIT timeout abort.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NUM_MASTERS = NUM_MASTERS_DEF,
   parameter int ID_W        = $clog2(NUM_MASTERS),
   parameter int TIMEOUT     = TIMEOUT_DEF,
   parameter int TMO_W       = TMO_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_MASTERS-1:0] bus_req,
   input  logic                   slave_wait,
   output logic [NUM_MASTERS-1:0] bus_ack,
   output logic [ID_W-1:0]        owner,
   output logic                   bus_busy,
   output logic                   addr_phase,
   output logic                   data_phase,
   output logic                   timeout_err
);

   bus_phase_e       state_r;
   bus_phase_e       next_state_s;
   logic [ID_W-1:0]  owner_r;
   logic [ID_W-1:0]  ptr_r;
   logic [TMO_W-1:0] wait_cnt_r;
   logic             busy_r;
   logic             addr_r;
   logic             data_r;
   logic             tmo_r;
   logic             pick_valid_s;
   logic [ID_W-1:0]  pick_winner_s;
   logic             ack_hit_s;
   logic             tmo_hit_s;

   rr_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .ID_W        (ID_W)
   ) u_picker (
      .req    (bus_req),
      .ptr    (ptr_r),
      .valid  (pick_valid_s),
      .winner (pick_winner_s)
   );

   // The grant only lands while the chosen master still holds its request.
   assign ack_hit_s = (state_r == ST_GRANT) && bus_req[owner_r];
   // Abort on the TIMEOUT-th consecutive stalled WAIT cycle.
   assign tmo_hit_s = (state_r == ST_WAIT) && slave_wait &&
                      (wait_cnt_r >= TMO_W'(TIMEOUT - 1));

   // Phase state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-phase decode.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE:   next_state_s = pick_valid_s ? ST_GRANT : ST_IDLE;
         ST_GRANT:  next_state_s = ack_hit_s ? ST_ADDR : ST_IDLE;
         ST_ADDR:   next_state_s = ST_WAIT;
         ST_WAIT: begin
            if (!slave_wait) begin
               next_state_s = ST_DATA;
            end else if (tmo_hit_s) begin
               next_state_s = ST_FINISH;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_DATA:   next_state_s = ST_FINISH;
         ST_FINISH: next_state_s = ST_IDLE;
         default:   next_state_s = ST_IDLE;
      endcase
   end

   // Owner, rotation pointer and saturating wait counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_r    <= '0;
         ptr_r      <= '0;
         wait_cnt_r <= '0;
      end else begin
         owner_r <= ((state_r == ST_IDLE) && pick_valid_s) ? pick_winner_s : owner_r;
         if (ack_hit_s) begin
            ptr_r <= (owner_r == ID_W'(NUM_MASTERS - 1)) ? '0 : (owner_r + ID_W'(1));
         end else begin
            ptr_r <= ptr_r;
         end
         if (state_r == ST_ADDR) begin
            wait_cnt_r <= '0;
         end else if ((state_r == ST_WAIT) && slave_wait && (wait_cnt_r < TMO_W'(TIMEOUT))) begin
            wait_cnt_r <= wait_cnt_r + TMO_W'(1);
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
      end
   end

   // Phase flags are registered from the next phase so they track state_r exactly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_r <= 1'b0;
         addr_r <= 1'b0;
         data_r <= 1'b0;
         tmo_r  <= 1'b0;
      end else begin
         busy_r <= (next_state_s != ST_IDLE);
         addr_r <= (next_state_s == ST_ADDR);
         data_r <= (next_state_s == ST_DATA);
         tmo_r  <= tmo_hit_s;
      end
   end

   // One-hot grant pulse, all-zero outside GRANT.
   always_comb begin
      bus_ack = '0;
      if (ack_hit_s) begin
         bus_ack[owner_r] = 1'b1;
      end else begin
         bus_ack = '0;
      end
   end

   assign owner       = owner_r;
   assign bus_busy    = busy_r;
   assign addr_phase  = addr_r;
   assign data_phase  = data_r;
   assign timeout_err = tmo_r;

endmodule
